// File: rtl/booth_mul_if.sv
// Request/response bundle for the sequential Booth multiplier.
// The master issues operands and accepts results; the slave is the multiplier.
interface booth_mul_if #(
  parameter int W = 64
);
  logic         mul_valid;
  logic         mul_ready;
  logic [1:0]   mul_signed;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result_hi;
  logic [W-1:0] result_lo;

  modport master (
    output mul_valid, mul_signed, multiplicand, multiplier, out_ready,
    input  mul_ready, out_valid, result_hi, result_lo
  );

  modport slave (
    input  mul_valid, mul_signed, multiplicand, multiplier, out_ready,
    output mul_ready, out_valid, result_hi, result_lo
  );
endinterface

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier retiring UNROLL digits per cycle.
// Operands are latched on accept; the product is held in DONE until out_ready.
//
// state  | meaning
// S_IDLE | ready for a request (mul_ready=1)
// S_CALC | accumulating Booth partial products, one cycle per counter value
// S_DONE | product valid, waiting for out_ready
module booth_seq_multiplier #(
  parameter int W      = 64,
  parameter int UNROLL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  booth_mul_if.slave mul_if
);

  localparam int AW    = 2*W + 4;
  localparam int BW    = W + 3;
  localparam int NSTEP = (W + 2 + 2*UNROLL - 1) / (2*UNROLL);
  localparam int CW    = $clog2(NSTEP + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic pos;
    logic pos2;
    logic neg;
    logic neg2;
  } booth_sel_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] mcand_q, mcand_d;
  logic [BW-1:0] mplr_q, mplr_d;
  logic [W-1:0]  res_hi_q, res_hi_d;
  logic [W-1:0]  res_lo_q, res_lo_d;

  logic [AW-1:0] acc_sum;
  logic [AW-1:0] pp_base;
  logic [AW-1:0] pp_mag;
  logic [AW-1:0] pp;
  logic          pp_neg;
  booth_sel_t    sel;
  logic          ext_a;
  logic          ext_b;

  function automatic booth_sel_t booth_sel(input logic [2:0] win);
    booth_sel_t s;
    s = '0;
    case (win)
      3'b001, 3'b010: s.pos  = 1'b1;
      3'b011:         s.pos2 = 1'b1;
      3'b100:         s.neg2 = 1'b1;
      3'b101, 3'b110: s.neg  = 1'b1;
      default:        s      = '0;
    endcase
    return s;
  endfunction

  // Negative digits add the one's complement plus a carry-in in the same add.
  always_comb begin
    acc_sum = acc_q;
    pp_base = '0;
    pp_mag  = '0;
    pp      = '0;
    pp_neg  = 1'b0;
    sel     = '0;
    for (int j = 0; j < UNROLL; j++) begin
      sel     = booth_sel(mplr_q[2*j +: 3]);
      pp_base = mcand_q << (2*j);
      pp_mag  = (sel.pos2 | sel.neg2) ? (pp_base << 1) : pp_base;
      if (!(sel.pos | sel.pos2 | sel.neg | sel.neg2)) pp_mag = '0;
      pp_neg  = sel.neg | sel.neg2;
      pp      = pp_neg ? ~pp_mag : pp_mag;
      acc_sum = acc_sum + pp + AW'(pp_neg);
    end
  end

  assign ext_a = mul_if.mul_signed[1] & mul_if.multiplicand[W-1];
  assign ext_b = mul_if.mul_signed[0] & mul_if.multiplier[W-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;

    case (state_q)
      S_IDLE: begin
        if (mul_if.mul_valid) begin
          mcand_d = {{(W+4){ext_a}}, mul_if.multiplicand};
          mplr_d  = {{2{ext_b}}, mul_if.multiplier, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << (2*UNROLL);
        // Arithmetic shift keeps surplus windows at 000/111, i.e. digit zero.
        mplr_d  = BW'($signed(mplr_q) >>> (2*UNROLL));
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NSTEP - 1)) begin
          res_hi_d = acc_sum[2*W-1:W];
          res_lo_d = acc_sum[W-1:0];
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (mul_if.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign mul_if.mul_ready = (state_q == S_IDLE);
  assign mul_if.out_valid = (state_q == S_DONE);
  assign mul_if.result_hi = res_hi_q;
  assign mul_if.result_lo = res_lo_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed and random checks of booth_seq_multiplier at W=64/UNROLL=1 and W=32/UNROLL=2.
module tb_booth_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  booth_mul_if #(.W(64)) if64 ();
  booth_mul_if #(.W(32)) if32 ();

  booth_seq_multiplier #(.W(64), .UNROLL(1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .mul_if(if64.slave));
  booth_seq_multiplier #(.W(32), .UNROLL(2)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .mul_if(if32.slave));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_prod(input int w, input logic [1:0] mode,
                                            input logic [63:0] a, input logic [63:0] b);
    logic signed [131:0] ea, eb, p;
    logic [63:0] m;
    m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    ea = $signed({68'b0, a & m});
    eb = $signed({68'b0, b & m});
    if (mode[1] && a[w-1]) ea = ea - (132'sd1 <<< w);
    if (mode[0] && b[w-1]) eb = eb - (132'sd1 <<< w);
    p = ea * eb;
    return (w == 64) ? p[127:0] : {64'b0, p[63:0]};
  endfunction

  function automatic logic rdy(input bit big);
    return big ? if64.mul_ready : if32.mul_ready;
  endfunction

  function automatic logic ov(input bit big);
    return big ? if64.out_valid : if32.out_valid;
  endfunction

  function automatic logic [127:0] rd(input bit big);
    return big ? {if64.result_hi, if64.result_lo} : {64'b0, if32.result_hi, if32.result_lo};
  endfunction

  task automatic set_req(input bit big, input logic v, input logic [1:0] mode,
                         input logic [63:0] a, input logic [63:0] b);
    if (big) begin
      if64.mul_valid = v; if64.mul_signed = mode; if64.multiplicand = a; if64.multiplier = b;
    end else begin
      if32.mul_valid = v; if32.mul_signed = mode;
      if32.multiplicand = a[31:0]; if32.multiplier = b[31:0];
    end
  endtask

  task automatic set_ordy(input bit big, input logic v);
    if (big) if64.out_ready = v;
    else     if32.out_ready = v;
  endtask

  // Leaves the bench 1 time unit after the accepting edge, operands scrambled.
  task automatic start(input bit big, input logic [1:0] mode, input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    set_req(big, 1'b1, mode, a, b);
    while (!rdy(big) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check("accept_timeout", rdy(big), 1);
    @(posedge clk); #1;
    set_req(big, 1'b0, ~mode, ~a, ~b);
  endtask

  // lat counts the accepting edge as edge 1.
  task automatic wait_done(input bit big, output int lat);
    lat = 1;
    while (!ov(big) && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic ack(input bit big);
    set_ordy(big, 1'b1);
    @(posedge clk); #1;
    set_ordy(big, 1'b0);
  endtask

  task automatic run(input bit big, input logic [1:0] mode, input logic [63:0] a, input logic [63:0] b,
                     input logic [127:0] exp, input string tag);
    int lat;
    start(big, mode, a, b);
    wait_done(big, lat);
    check({tag, "_lat"}, lat, big ? 34 : 10);
    check(tag, rd(big), exp);
    ack(big);
  endtask

  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;

  initial begin
    int lat;
    logic [127:0] held;
    logic [63:0]  ra, rb;
    logic [1:0]   rm;

    rst_n = 1'b0;
    flush = 1'b0;
    set_req(1, 0, 2'b00, 0, 0); set_req(0, 0, 2'b00, 0, 0);
    set_ordy(1, 0); set_ordy(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready64", rdy(1), 1);
    check("rst_valid64", ov(1), 0);
    check("rst_res64",   rd(1), 0);
    check("rst_ready32", rdy(0), 1);
    check("rst_valid32", ov(0), 0);
    check("rst_res32",   rd(0), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(1, 2'b11, ONES64, ONES64, {64'h0, 64'h1}, "s11_m1xm1");
    run(1, 2'b00, ONES64, ONES64, {64'hFFFF_FFFF_FFFF_FFFE, 64'h1}, "u00_maxsq");
    run(1, 2'b10, ONES64, ONES64, {ONES64, 64'h1}, "m10_m1xmax");
    run(1, 2'b11, MIN64, MIN64, {64'h4000_0000_0000_0000, 64'h0}, "s11_minsq");
    run(1, 2'b11, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, {ONES64, 64'hFFFF_FFFF_FFFF_FFEB}, "s11_7xm3");

    // Illegal mode still completes on time.
    start(1, 2'b01, 64'd12345, ONES64);
    wait_done(1, lat);
    check("mode01_lat", lat, 34);
    ack(1);

    // Back-pressure in DONE.
    start(1, 2'b00, 64'd1000, 64'd999);
    wait_done(1, lat);
    held = rd(1);
    check("bp_res", held, 128'd999000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", ov(1), 1);
      check("bp_hold",  rd(1), held);
      check("bp_ready", rdy(1), 0);
    end
    ack(1);
    check("bp_ack_valid", ov(1), 0);
    check("bp_ack_ready", rdy(1), 1);
    set_req(1, 1, 2'b11, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE);
    @(posedge clk); #1;
    check("bp_next_accept", rdy(1), 0);
    set_req(1, 0, 2'b00, 0, 0);
    wait_done(1, lat);
    check("bp_next_lat", lat, 34);
    check("bp_next_res", rd(1), {ONES64, 64'hFFFF_FFFF_FFFF_FFF4});
    ack(1);

    // Flush at counter=5, then a fresh request.
    start(1, 2'b11, ONES64, ONES64);
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_valid", ov(1), 0);
    check("flush_ready", rdy(1), 1);
    run(1, 2'b00, 64'd3, 64'd5, {64'h0, 64'd15}, "flush_3x5");

    // Flush beats a simultaneous request in IDLE.
    set_req(1, 1, 2'b00, 64'd2, 64'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    set_req(1, 0, 2'b00, 0, 0);
    check("flush_prio_ready", rdy(1), 1);
    @(posedge clk); #1;
    check("flush_prio_valid", ov(1), 0);

    // Reset at counter=5.
    start(1, 2'b11, ONES64, ONES64);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready", rdy(1), 1);
    check("midrst_valid", ov(1), 0);
    check("midrst_res",   rd(1), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(0, 2'b11, ONES64, ONES64, {64'h0, 32'h0, 32'h1}, "w32_s11");
    run(0, 2'b00, ONES64, ONES64, {64'h0, 32'hFFFF_FFFE, 32'h1}, "w32_u00");
    run(0, 2'b10, ONES64, ONES64, {64'h0, 32'hFFFF_FFFF, 32'h1}, "w32_m10");
    run(0, 2'b11, 64'h8000_0000, 64'h8000_0000, {64'h0, 32'h4000_0000, 32'h0}, "w32_minsq");

    for (int i = 0; i < 1500; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0:       rm = 2'b00;
        1:       rm = 2'b10;
        default: rm = 2'b11;
      endcase
      start(0, rm, ra, rb);
      wait_done(0, lat);
      check("rnd32_lat", lat, 10);
      check("rnd32", rd(0), ref_prod(32, rm, ra, rb));
      ack(0);
    end

    for (int i = 0; i < 300; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0:       rm = 2'b00;
        1:       rm = 2'b10;
        default: rm = 2'b11;
      endcase
      start(1, rm, ra, rb);
      wait_done(1, lat);
      check("rnd64_lat", lat, 34);
      check("rnd64", rd(1), ref_prod(64, rm, ra, rb));
      ack(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
